// File: rtl/restador_sat_pipe.sv
// Two-stage signed saturating subtractor (result = minuend - subtrahend) with
// valid/ready flow control, sticky saturation flag and saturating event counter.
module restador_sat_pipe #(
    parameter int unsigned N     = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N-1:0]     minuend,
    input  logic [2*N-1:0]     subtrahend,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N-1:0]     result,
    output logic               sat_pos,
    output logic               sat_neg,
    output logic               sat_flag,
    output logic [CNT_W-1:0]   sat_count,
    input  logic               clr_flag
);

    localparam int unsigned    W       = 2 * N;
    localparam logic [W-1:0]   POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]   NEG_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_q,  s1_valid_d;
    logic [W-1:0]     raw_q,       raw_d;
    logic             ovf_pos_q,   ovf_pos_d;
    logic             ovf_neg_q,   ovf_neg_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     result_q,    result_d;
    logic             sat_pos_q,   sat_pos_d;
    logic             sat_neg_q,   sat_neg_d;
    logic             sat_flag_q,  sat_flag_d;
    logic [CNT_W-1:0] sat_count_q, sat_count_d;

    logic             advance_c;
    logic             event_c;
    logic [W-1:0]     diff_c;

    // Next-state logic: whole pipe advances together or holds
    always_comb begin
        s1_valid_d  = s1_valid_q;
        raw_d       = raw_q;
        ovf_pos_d   = ovf_pos_q;
        ovf_neg_d   = ovf_neg_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        sat_pos_d   = sat_pos_q;
        sat_neg_d   = sat_neg_q;
        sat_flag_d  = sat_flag_q;
        sat_count_d = sat_count_q;

        advance_c = ~out_valid_q | out_ready;
        diff_c    = W'(minuend - subtrahend);
        event_c   = out_valid_q & out_ready & (sat_pos_q | sat_neg_q);

        if (advance_c) begin
            s1_valid_d  = in_valid;
            out_valid_d = s1_valid_q;
            if (in_valid) begin
                raw_d     = diff_c;
                ovf_pos_d = ~minuend[W-1] &  subtrahend[W-1] &  diff_c[W-1];
                ovf_neg_d =  minuend[W-1] & ~subtrahend[W-1] & ~diff_c[W-1];
            end
            // Bubbles leave the output data registers untouched
            if (s1_valid_q) begin
                result_d  = ovf_pos_q ? POS_MAX : (ovf_neg_q ? NEG_MIN : raw_q);
                sat_pos_d = ovf_pos_q;
                sat_neg_d = ovf_neg_q;
            end
        end

        // A saturating transfer outranks a simultaneous clear
        if (event_c) begin
            sat_flag_d = 1'b1;
            if (clr_flag) begin
                sat_count_d = CNT_W'(1);
            end else if (sat_count_q != CNT_MAX) begin
                sat_count_d = sat_count_q + CNT_W'(1);
            end
        end else if (clr_flag) begin
            sat_flag_d  = 1'b0;
            sat_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            raw_q       <= '0;
            ovf_pos_q   <= 1'b0;
            ovf_neg_q   <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sat_pos_q   <= 1'b0;
            sat_neg_q   <= 1'b0;
            sat_flag_q  <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            raw_q       <= raw_d;
            ovf_pos_q   <= ovf_pos_d;
            ovf_neg_q   <= ovf_neg_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            sat_pos_q   <= sat_pos_d;
            sat_neg_q   <= sat_neg_d;
            sat_flag_q  <= sat_flag_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign in_ready  = advance_c;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign sat_pos   = sat_pos_q;
    assign sat_neg   = sat_neg_q;
    assign sat_flag  = sat_flag_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_restador_sat_pipe.sv
// Bench for restador_sat_pipe: directed edge cases, backpressure, status counter,
// reset mid-flight and randomized traffic against an arithmetic reference model.
module tb_restador_sat_pipe;

    localparam int unsigned N     = 16;
    localparam int unsigned W     = 2 * N;
    localparam int unsigned CNT_W = 8;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, in_valid, in_ready, out_valid, out_ready;
    logic             sat_pos, sat_neg, sat_flag, clr_flag;
    logic [W-1:0]     minuend, subtrahend, result;
    logic [CNT_W-1:0] sat_count;

    restador_sat_pipe #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .minuend(minuend), .subtrahend(subtrahend), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .sat_pos(sat_pos), .sat_neg(sat_neg),
        .sat_flag(sat_flag), .sat_count(sat_count), .clr_flag(clr_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         pos;
        logic         neg;
        int           cyc;
    } xfer_t;

    xfer_t exp_q[$], want_q[$], got_q[$];
    int    cyc, n_checks, n_pass, spurious, model_cnt;
    logic  model_flag;

    localparam logic [W-1:0] DA [8] = '{32'd100, 32'd5, 32'h7FFFFFF0, 32'h0,
                                        32'h80000010, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
    localparam logic [W-1:0] DB [8] = '{32'd30, 32'd12, 32'hFFFFFF00, 32'h80000000,
                                        32'h00000100, 32'h7FFFFFFF, 32'h80000000, 32'h12345678};
    localparam logic [W-1:0] DR [8] = '{32'd70, 32'hFFFFFFF9, 32'h7FFFFFFF, 32'h7FFFFFFF,
                                        32'h80000000, 32'h80000000, 32'h0, 32'h0};
    localparam logic [7:0]   DP     = 8'b0000_1100;
    localparam logic [7:0]   DN     = 8'b0001_0000;

    // Reference: exact difference in 64 bits, then clamp into W-bit signed range
    function automatic xfer_t ref_sub(logic [W-1:0] a, logic [W-1:0] b, int c);
        longint d, hi, lo;
        xfer_t  t;
        hi = (longint'(1) <<< (W - 1)) - 1;
        lo = -(longint'(1) <<< (W - 1));
        d  = longint'($signed(a)) - longint'($signed(b));
        t.pos = 1'b0;
        t.neg = 1'b0;
        t.cyc = c;
        if (d > hi) begin
            t.res = W'(hi);
            t.pos = 1'b1;
        end else if (d < lo) begin
            t.res = W'(lo);
            t.neg = 1'b1;
        end else begin
            t.res = W'(d);
        end
        return t;
    endfunction

    function automatic logic [W-1:0] pick_op();
        case ($urandom % 6)
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h7FFFFFFF;
            4:       return 32'h80000000;
            default: return W'($urandom);
        endcase
    endfunction

    // One clock: record handshakes just before the edge, update the status model
    task automatic tick();
        xfer_t g, w;
        logic  ev;
        #1;
        if (reset) begin
            exp_q.delete();
            model_flag = 1'b0;
            model_cnt  = 0;
        end else begin
            ev = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    spurious++;
                end else begin
                    w     = exp_q.pop_front();
                    g.res = result;
                    g.pos = sat_pos;
                    g.neg = sat_neg;
                    g.cyc = cyc;
                    got_q.push_back(g);
                    want_q.push_back(w);
                    ev = w.pos || w.neg;
                end
            end
            if (ev) begin
                model_flag = 1'b1;
                model_cnt  = clr_flag ? 1 : ((model_cnt < CMAX) ? model_cnt + 1 : CMAX);
            end else if (clr_flag) begin
                model_flag = 1'b0;
                model_cnt  = 0;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_sub(minuend, subtrahend, cyc));
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_flag = 1'b0;
        minuend = '0; subtrahend = '0;
        tick(); tick();
        reset = 1'b0;
        n_checks++;
        if ({out_valid, sat_pos, sat_neg, sat_flag} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {out_valid, sat_pos, sat_neg, sat_flag});
        else n_pass++;
        n_checks++;
        if (result !== '0) $display("FAIL reset_result: got %h want 0", result);
        else n_pass++;
        n_checks++;
        if (sat_count !== '0) $display("FAIL reset_count: got %0d want 0", sat_count);
        else n_pass++;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        xfer_t g, w;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; minuend = DA[i]; subtrahend = DB[i];
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (got_q.size() !== 8) $display("FAIL directed_count: got %0d want 8", got_q.size());
        else n_pass++;
        for (int i = 0; i < 8 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            w = want_q.pop_front();
            n_checks++;
            if (g.res !== DR[i] || g.pos !== DP[i] || g.neg !== DN[i])
                $display("FAIL directed_%0d: got %h p%b n%b want %h p%b n%b", i, g.res, g.pos, g.neg, DR[i], DP[i], DN[i]);
            else n_pass++;
            n_checks++;
            if (g.cyc - w.cyc !== 2) $display("FAIL directed_latency_%0d: got %0d want 2", i, g.cyc - w.cyc);
            else n_pass++;
        end
        n_checks++;
        if (sat_flag !== 1'b1 || sat_count !== 8'd3) $display("FAIL directed_status: got flag %b count %0d want 1 3", sat_flag, sat_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] pa [4], pb [4], held;
        xfer_t g, w;
        int sent, stall;
        sent = 0; stall = -1; held = '0;
        for (int i = 0; i < 4; i++) begin pa[i] = pick_op(); pb[i] = pick_op(); end
        out_ready = 1'b1;
        for (int k = 0; k < 40 && got_q.size() < 4; k++) begin
            in_valid   = (sent < 4);
            minuend    = pa[sent & 3];
            subtrahend = pb[sent & 3];
            if (stall < 0 && out_valid) begin stall = 3; held = result; end
            out_ready = (stall <= 0);
            #1;
            if (stall > 0) begin
                n_checks++;
                if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready);
                else n_pass++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            if (stall > 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || result !== held) $display("FAIL bp_hold: got v%b %h want v1 %h", out_valid, result, held);
                else n_pass++;
                stall--;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (stall !== 0 || got_q.size() !== 4 || exp_q.size() !== 0)
            $display("FAIL bp_delivery: got stall %0d outs %0d pending %0d want 0 4 0", stall, got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            w = want_q.pop_front();
            n_checks++;
            if (g.res !== w.res || g.pos !== w.pos || g.neg !== w.neg || w.res !== ref_sub(pa[i], pb[i], 0).res)
                $display("FAIL bp_order_%0d: got %h p%b n%b want %h p%b n%b", i, g.res, g.pos, g.neg, w.res, w.pos, w.neg);
            else n_pass++;
        end
    endtask

    task automatic test_status();
        xfer_t g, w;
        int bad;
        reset = 1'b1; in_valid = 1'b0; clr_flag = 1'b0; tick(); reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            in_valid = 1'b1; minuend = W'($urandom) & 32'h7FFFFFFF; subtrahend = 32'h80000000;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bad = 0;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            w = want_q.pop_front();
            if (g.res !== w.res || g.pos !== 1'b1 || g.neg !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL status_results: got %0d bad want 0", bad);
        else n_pass++;
        n_checks++;
        if (sat_count !== 8'hFF || sat_flag !== 1'b1 || model_cnt !== CMAX)
            $display("FAIL status_saturate: got flag %b count %0d want 1 255", sat_flag, sat_count);
        else n_pass++;
        in_valid = 1'b1; minuend = 32'h0; subtrahend = 32'h80000000;
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || sat_pos !== 1'b1) $display("FAIL status_pending: got v%b p%b want v1 p1", out_valid, sat_pos);
        else n_pass++;
        clr_flag = 1'b1; tick(); clr_flag = 1'b0;
        n_checks++;
        if (sat_flag !== 1'b1 || sat_count !== 8'd1) $display("FAIL status_clr_event: got flag %b count %0d want 1 1", sat_flag, sat_count);
        else n_pass++;
        clr_flag = 1'b1; tick(); clr_flag = 1'b0;
        n_checks++;
        if (sat_flag !== 1'b0 || sat_count !== 8'd0) $display("FAIL status_clr_alone: got flag %b count %0d want 0 0", sat_flag, sat_count);
        else n_pass++;
        got_q.delete(); want_q.delete();
    endtask

    task automatic test_reset_midflight();
        xfer_t g, w;
        out_ready = 1'b0;
        in_valid = 1'b1; minuend = 32'h0; subtrahend = 32'h80000000; tick();
        minuend = 32'h80000010; subtrahend = 32'h100; tick();
        in_valid = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
        n_checks++;
        if ({out_valid, sat_pos, sat_neg, sat_flag} !== 4'b0000 || result !== '0 || sat_count !== '0)
            $display("FAIL midreset_outputs: got v%b p%b n%b f%b %h %0d want all 0", out_valid, sat_pos, sat_neg, sat_flag, result, sat_count);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (got_q.size() !== 0 || spurious !== 0) $display("FAIL midreset_ghost: got %0d outs %0d spurious want 0 0", got_q.size(), spurious);
        else n_pass++;
        in_valid = 1'b1; minuend = 32'd1000; subtrahend = 32'd1; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (got_q.size() !== 1) $display("FAIL midreset_count: got %0d want 1", got_q.size());
        else begin
            g = got_q.pop_front();
            w = want_q.pop_front();
            if (g.res !== 32'd999 || g.pos !== 1'b0 || g.neg !== 1'b0 || g.cyc - w.cyc !== 2)
                $display("FAIL midreset_new: got %h lat %0d want 000003e7 lat 2", g.res, g.cyc - w.cyc);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        xfer_t g, w;
        for (int i = 0; i < 300; i++) begin
            in_valid   = ($urandom % 4) != 0;
            out_ready  = ($urandom % 4) != 0;
            clr_flag   = ($urandom % 16) == 0;
            minuend    = pick_op();
            subtrahend = pick_op();
            tick();
            n_checks++;
            if (sat_flag !== model_flag || sat_count !== CNT_W'(model_cnt))
                $display("FAIL rand_status_%0d: got flag %b count %0d want %b %0d", i, sat_flag, sat_count, model_flag, model_cnt);
            else n_pass++;
        end
        in_valid = 1'b0; out_ready = 1'b1; clr_flag = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            w = want_q.pop_front();
            n_checks++;
            if (g.res !== w.res || g.pos !== w.pos || g.neg !== w.neg)
                $display("FAIL rand_result: got %h p%b n%b want %h p%b n%b", g.res, g.pos, g.neg, w.res, w.pos, w.neg);
            else n_pass++;
        end
        n_checks++;
        if (exp_q.size() !== 0 || spurious !== 0) $display("FAIL rand_drain: got %0d pending %0d spurious want 0 0", exp_q.size(), spurious);
        else n_pass++;
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_pass = 0; spurious = 0;
        model_cnt = 0; model_flag = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_status();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
